// File: rtl/gpio_gen2_pkg.sv
// Shared register offsets, mode encodings and version constant for gpio_gen2.
package gpio_gen2_pkg;

    localparam logic [5:0] OFF_IN         = 6'h00;
    localparam logic [5:0] OFF_OUT        = 6'h01;
    localparam logic [5:0] OFF_OUT_SET    = 6'h02;
    localparam logic [5:0] OFF_OUT_CLR    = 6'h03;
    localparam logic [5:0] OFF_OE         = 6'h04;
    localparam logic [5:0] OFF_OD         = 6'h05;
    localparam logic [5:0] OFF_OS         = 6'h06;
    localparam logic [5:0] OFF_ALT_SEL0   = 6'h07;
    localparam logic [5:0] OFF_ALT_SEL1   = 6'h08;
    localparam logic [5:0] OFF_IRQ_EN     = 6'h09;
    localparam logic [5:0] OFF_IRQ_MODE0  = 6'h0A;
    localparam logic [5:0] OFF_IRQ_MODE1  = 6'h0B;
    localparam logic [5:0] OFF_IRQ_STATUS = 6'h0C;
    localparam logic [5:0] OFF_DB_THRESH  = 6'h0D;
    localparam logic [5:0] OFF_INFO       = 6'h0E;

    localparam logic [15:0] INFO_VERSION = 16'h0002;

    typedef enum logic [1:0] {RISE, FALL, BOTH, LEVEL} irq_mode_e;
    typedef enum logic [1:0] {GPIO, ALT, ALT1, ALT2} alt_sel_e;

    // The map is dense from offset 0 up to INFO.
    function automatic logic offset_mapped(input logic [5:0] off);
        return off <= OFF_INFO;
    endfunction

endpackage

// File: rtl/gpio_gen2_debounce.sv
// Single-pin debounce filter: the filtered value follows din only after din
// has differed from it for thresh+1 consecutive cycles.
module gpio_gen2_debounce #(
    parameter int DB_W = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    input  logic [DB_W-1:0] thresh,
    input  logic            din,
    output logic            filt
);

    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else if (din == filt) begin
            cnt <= '0;
        end else if (cnt >= thresh) begin
            filt <= din;
            cnt  <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_gen2.sv
// APB GPIO controller with alt-function muxing, sync/debounce and per-pin IRQs.
// Optional debounce filters are built when GPIO_GEN2_DEBOUNCE_EN is defined.
module gpio_gen2
    import gpio_gen2_pkg::*;
#(
    parameter int          NUM_PINS     = 32,
    parameter int          DB_W         = 8,
    parameter logic [31:0] DEF_ALT_SEL0 = '0,
    parameter logic [31:0] DEF_ALT_SEL1 = '0
) (
    input  logic                pclk_i,
    input  logic                prstn_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [31:0]         paddr_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                psuberr_o,
    input  logic [NUM_PINS-1:0] gpio_in_i,
    output logic [NUM_PINS-1:0] gpio_out_o,
    output logic [NUM_PINS-1:0] gpio_oen_o,
    input  logic [NUM_PINS-1:0] gpio_alt_in_i,
    input  logic [NUM_PINS-1:0] gpio_alt1_in_i,
    input  logic [NUM_PINS-1:0] gpio_alt2_in_i,
    input  logic [NUM_PINS-1:0] gpio_alt_oen_i,
    input  logic [NUM_PINS-1:0] gpio_alt1_oen_i,
    input  logic [NUM_PINS-1:0] gpio_alt2_oen_i,
    output logic [NUM_PINS-1:0] gpio_alt_out_o,
    output logic [NUM_PINS-1:0] gpio_alt1_out_o,
    output logic [NUM_PINS-1:0] gpio_alt2_out_o,
    output logic                irq_o
);

    logic [5:0]          offset;
    logic [NUM_PINS-1:0] wdata;
    logic                wr_en, rd_setup, mapped;

    logic [NUM_PINS-1:0] out_q, oe_q, od_q, os_q, alt_sel0_q, alt_sel1_q;
    logic [NUM_PINS-1:0] irq_en_q, irq_mode0_q, irq_mode1_q, irq_status_q;
    logic [NUM_PINS-1:0] sync0, sync1, filt, filt_d, evt, status_clr;
    logic [DB_W-1:0]     db_thresh;
    logic [31:0]         rdata, prdata_q;
    logic                irq_q;
    logic                unused_bits;

    assign offset      = paddr_i[7:2];
    assign wdata       = pwdata_i[NUM_PINS-1:0];
    assign mapped      = offset_mapped(offset);
    assign wr_en       = psel_i & penable_i & pwrite_i & mapped;
    assign rd_setup    = psel_i & ~penable_i & ~pwrite_i;
    assign unused_bits = ^{paddr_i[31:8], paddr_i[1:0], pwdata_i};

    assign pready_o  = 1'b1;
    assign psuberr_o = psel_i & penable_i & ~mapped;
    assign prdata_o  = prdata_q;
    assign irq_o     = irq_q;

    always_ff @(posedge pclk_i) begin
        if (!prstn_i) begin
            out_q       <= '0;
            oe_q        <= '0;
            od_q        <= '0;
            os_q        <= '0;
            alt_sel0_q  <= DEF_ALT_SEL0[NUM_PINS-1:0];
            alt_sel1_q  <= DEF_ALT_SEL1[NUM_PINS-1:0];
            irq_en_q    <= '0;
            irq_mode0_q <= '0;
            irq_mode1_q <= '0;
        end else if (wr_en) begin
            case (offset)
                OFF_OUT:       out_q       <= wdata;
                OFF_OUT_SET:   out_q       <= out_q | wdata;
                OFF_OUT_CLR:   out_q       <= out_q & ~wdata;
                OFF_OE:        oe_q        <= wdata;
                OFF_OD:        od_q        <= wdata;
                OFF_OS:        os_q        <= wdata;
                OFF_ALT_SEL0:  alt_sel0_q  <= wdata;
                OFF_ALT_SEL1:  alt_sel1_q  <= wdata;
                OFF_IRQ_EN:    irq_en_q    <= wdata;
                OFF_IRQ_MODE0: irq_mode0_q <= wdata;
                OFF_IRQ_MODE1: irq_mode1_q <= wdata;
                default: ;
            endcase
        end
    end

`ifdef GPIO_GEN2_DEBOUNCE_EN
    localparam logic [7:0] INFO_DBW = 8'(DB_W);
    logic thresh_wr;

    assign thresh_wr = wr_en && (offset == OFF_DB_THRESH);

    always_ff @(posedge pclk_i) begin
        if (!prstn_i)       db_thresh <= '0;
        else if (thresh_wr) db_thresh <= pwdata_i[DB_W-1:0];
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_db
        gpio_gen2_debounce #(.DB_W(DB_W)) u_db (
            .clk    (pclk_i),
            .rstn   (prstn_i),
            .clr    (thresh_wr),
            .thresh (db_thresh),
            .din    (sync1[i]),
            .filt   (filt[i])
        );
    end
`else
    localparam logic [7:0] INFO_DBW = 8'h00;

    assign db_thresh = '0;
    assign filt      = sync1;
`endif

    // Edge events compare the filtered value against its one-cycle-old copy.
    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (irq_mode_e'({irq_mode1_q[i], irq_mode0_q[i]}))
                RISE:    evt[i] = filt[i] & ~filt_d[i];
                FALL:    evt[i] = ~filt[i] & filt_d[i];
                BOTH:    evt[i] = filt[i] ^ filt_d[i];
                default: evt[i] = filt[i];
            endcase
        end
    end

    assign status_clr = (wr_en && (offset == OFF_IRQ_STATUS)) ? wdata : '0;

    // A new event overrides a same-cycle W1C of the same bit.
    always_ff @(posedge pclk_i) begin
        if (!prstn_i) begin
            sync0        <= '0;
            sync1        <= '0;
            filt_d       <= '0;
            irq_status_q <= '0;
            irq_q        <= 1'b0;
            prdata_q     <= '0;
        end else begin
            sync0        <= gpio_in_i;
            sync1        <= sync0;
            filt_d       <= filt;
            irq_status_q <= (irq_status_q & ~status_clr) | evt;
            irq_q        <= |(irq_status_q & irq_en_q);
            prdata_q     <= rd_setup ? rdata : '0;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_IN:         rdata = 32'(filt);
            OFF_OUT:        rdata = 32'(out_q);
            OFF_OE:         rdata = 32'(oe_q);
            OFF_OD:         rdata = 32'(od_q);
            OFF_OS:         rdata = 32'(os_q);
            OFF_ALT_SEL0:   rdata = 32'(alt_sel0_q);
            OFF_ALT_SEL1:   rdata = 32'(alt_sel1_q);
            OFF_IRQ_EN:     rdata = 32'(irq_en_q);
            OFF_IRQ_MODE0:  rdata = 32'(irq_mode0_q);
            OFF_IRQ_MODE1:  rdata = 32'(irq_mode1_q);
            OFF_IRQ_STATUS: rdata = 32'(irq_status_q);
            OFF_DB_THRESH:  rdata = 32'(db_thresh);
            OFF_INFO:       rdata = {INFO_VERSION, INFO_DBW, 8'(NUM_PINS)};
            default:        rdata = '0;
        endcase
    end

    always_comb begin
        gpio_out_o      = '0;
        gpio_oen_o      = '0;
        gpio_alt_out_o  = '0;
        gpio_alt1_out_o = '0;
        gpio_alt2_out_o = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (alt_sel_e'({alt_sel1_q[i], alt_sel0_q[i]}))
                ALT: begin
                    gpio_out_o[i]     = gpio_alt_in_i[i];
                    gpio_oen_o[i]     = gpio_alt_oen_i[i];
                    gpio_alt_out_o[i] = sync1[i];
                end
                ALT1: begin
                    gpio_out_o[i]      = gpio_alt1_in_i[i];
                    gpio_oen_o[i]      = gpio_alt1_oen_i[i];
                    gpio_alt1_out_o[i] = sync1[i];
                end
                ALT2: begin
                    gpio_out_o[i]      = gpio_alt2_in_i[i];
                    gpio_oen_o[i]      = gpio_alt2_oen_i[i];
                    gpio_alt2_out_o[i] = sync1[i];
                end
                default: begin
                    gpio_out_o[i] = out_q[i];
                    gpio_oen_o[i] = oe_q[i] & ((out_q[i] ^ os_q[i]) | ~od_q[i]);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_gen2.sv
// Directed plus randomized bench for gpio_gen2 (8 pins, pin0 defaults to alt).
module tb_gpio_gen2;

    localparam int NP = 8;

    localparam logic [5:0] A_IN = 6'h00, A_OUT = 6'h01, A_SET = 6'h02, A_CLR = 6'h03;
    localparam logic [5:0] A_OE = 6'h04, A_OD = 6'h05, A_OS = 6'h06;
    localparam logic [5:0] A_SEL0 = 6'h07, A_SEL1 = 6'h08, A_EN = 6'h09;
    localparam logic [5:0] A_M0 = 6'h0A, A_M1 = 6'h0B, A_ST = 6'h0C;
    localparam logic [5:0] A_DB = 6'h0D, A_INFO = 6'h0E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          prstn, psel, penable, pwrite;
    logic [31:0]   paddr, pwdata, prdata;
    logic          pready, psuberr, irq;
    logic [NP-1:0] gpio_in, gpio_out, gpio_oen;
    logic [NP-1:0] alt_in, alt1_in, alt2_in, alt_oen, alt1_oen, alt2_oen;
    logic [NP-1:0] alt_out, alt1_out, alt2_out;

    int total = 0;
    int bad   = 0;

    gpio_gen2 #(
        .NUM_PINS(NP), .DB_W(8), .DEF_ALT_SEL0(32'h01), .DEF_ALT_SEL1(32'h00)
    ) dut (
        .pclk_i(clk), .prstn_i(prstn), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .psuberr_o(psuberr), .gpio_in_i(gpio_in),
        .gpio_out_o(gpio_out), .gpio_oen_o(gpio_oen),
        .gpio_alt_in_i(alt_in), .gpio_alt1_in_i(alt1_in), .gpio_alt2_in_i(alt2_in),
        .gpio_alt_oen_i(alt_oen), .gpio_alt1_oen_i(alt1_oen), .gpio_alt2_oen_i(alt2_oen),
        .gpio_alt_out_o(alt_out), .gpio_alt1_out_o(alt1_out), .gpio_alt2_out_o(alt2_out),
        .irq_o(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [5:0] off, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = {24'h0, off, 2'b00}; pwdata = data;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] off, output logic [31:0] data, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = {24'h0, off, 2'b00};
        tick();
        penable = 1'b1;
        #1;
        data = prdata;
        err  = psuberr;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [5:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(off, d, e);
        check(tag, d, exp);
    endtask

    // Events a pin transition prev->cur raises under each interrupt mode.
    function automatic logic [NP-1:0] model_events(input logic [NP-1:0] prev, cur, m0, m1);
        logic [NP-1:0] ev;
        ev = '0;
        for (int i = 0; i < NP; i++) begin
            case ({m1[i], m0[i]})
                2'd0:    ev[i] = cur[i] && !prev[i];
                2'd1:    ev[i] = !cur[i] && prev[i];
                2'd2:    ev[i] = cur[i] != prev[i];
                default: ev[i] = cur[i];
            endcase
        end
        return ev;
    endfunction

    function automatic logic [NP-1:0] model_oen(input logic [NP-1:0] o, oe, od, os);
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++)
            r[i] = oe[i] && ((o[i] != os[i]) || !od[i]);
        return r;
    endfunction

    initial begin
        logic [31:0]   d;
        logic          e;
        logic [NP-1:0] en, m0, m1, st, v, p, m, ov, oev, odv, osv;

        prstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0;
        alt_in = 8'hFF; alt_oen = 8'hFF;
        alt1_in = '0; alt1_oen = '0; alt2_in = '0; alt2_oen = '0;
        tick();
        tick();
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_suberr", 32'(psuberr), 32'h0);
        check("rst_pad_out", 32'(gpio_out), 32'h01);
        check("rst_pad_oen", 32'(gpio_oen), 32'h01);
        check("rst_alt_out", 32'(alt_out), 32'h0);
        prstn = 1'b1;
        tick();
        read_check("rst_alt_sel0", A_SEL0, 32'h1);
        read_check("rst_alt_sel1", A_SEL1, 32'h0);
        read_check("rst_in", A_IN, 32'h0);
        check("pready", 32'(pready), 32'h1);

        // Synchronised value reaches the selected alt function two edges later.
        gpio_in = 8'h01;
        tick();
        check("alt_sync_early", 32'(alt_out), 32'h0);
        tick();
        check("alt_sync", 32'(alt_out), 32'h01);
        check("alt1_unsel", 32'(alt1_out), 32'h0);

        // Pin0 alt, pin1 alt1, pin2 alt2.
        apb_write(A_SEL0, 32'h05);
        apb_write(A_SEL1, 32'h06);
        alt1_in = 8'hFF; alt2_in = 8'h00;
        alt1_oen = 8'h00; alt2_oen = 8'hFF;
        gpio_in = 8'h07;
        tick();
        tick();
        check("mux_out", 32'(gpio_out), 32'h03);
        check("mux_oen", 32'(gpio_oen), 32'h05);
        check("mux_alt_out", 32'(alt_out), 32'h01);
        check("mux_alt1_out", 32'(alt1_out), 32'h02);
        check("mux_alt2_out", 32'(alt2_out), 32'h04);
        apb_write(A_SEL0, 32'h0);
        apb_write(A_SEL1, 32'h0);
        gpio_in = '0;
        repeat (6) tick();
        apb_write(A_ST, 32'hFF);
        read_check("status_cleared", A_ST, 32'h0);

        // Mapping, INFO, debounce threshold register, unmapped access.
        apb_write(A_DB, 32'h5);
`ifdef GPIO_GEN2_DEBOUNCE_EN
        read_check("db_thresh", A_DB, 32'h5);
        read_check("info", A_INFO, 32'h0002_0808);
        apb_write(A_DB, 32'h0);
`else
        read_check("db_thresh", A_DB, 32'h0);
        read_check("info", A_INFO, 32'h0002_0008);
`endif
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'h0, 6'h3F, 2'b00};
        #1;
        check("unmapped_setup_err", 32'(psuberr), 32'h0);
        tick();
        penable = 1'b1;
        #1;
        check("unmapped_prdata", prdata, 32'h0);
        check("unmapped_err", 32'(psuberr), 32'h1);
        tick();
        psel = 1'b0; penable = 1'b0;
        #1;
        check("unmapped_idle_err", 32'(psuberr), 32'h0);

        // OUT with set/clear, open-drain/open-source pad enable.
        apb_write(A_OUT, 32'hF0);
        apb_write(A_SET, 32'h03);
        apb_write(A_CLR, 32'h80);
        read_check("out_set_clr", A_OUT, 32'h73);
        read_check("out_set_reads0", A_SET, 32'h0);
        read_check("out_clr_reads0", A_CLR, 32'h0);
        apb_write(6'h10, 32'hFF);
        read_check("unmapped_write", A_OUT, 32'h73);
        apb_write(A_OE, 32'hFF);
        apb_write(A_OD, 32'h01);
        apb_write(A_OS, 32'h00);
        check("pad_out", 32'(gpio_out), 32'h73);
        check("pad_oen_od", 32'(gpio_oen), 32'(model_oen(8'h73, 8'hFF, 8'h01, 8'h00)));
        apb_write(A_OS, 32'h01);
        check("pad_oen_os", 32'(gpio_oen), 32'(model_oen(8'h73, 8'hFF, 8'h01, 8'h01)));
        apb_write(A_CLR, 32'h01);
        check("pad_oen_os_low", 32'(gpio_oen), 32'(model_oen(8'h72, 8'hFF, 8'h01, 8'h01)));

        // Rising edge on pin3: status after N+2, irq after N+3, W1C drops irq.
        apb_write(A_EN, 32'h08);
        gpio_in = 8'h08;
        tick();
        tick();
        tick();
        check("rise_irq_early", 32'(irq), 32'h0);
        tick();
        check("rise_irq", 32'(irq), 32'h1);
        read_check("rise_status", A_ST, 32'h08);
        read_check("rise_in", A_IN, 32'h08);
        apb_write(A_ST, 32'h08);
        check("w1c_irq_hold", 32'(irq), 32'h1);
        tick();
        check("w1c_irq_drop", 32'(irq), 32'h0);
        read_check("w1c_status", A_ST, 32'h0);

        // Level-high keeps re-setting status through a W1C.
        apb_write(A_M0, 32'h08);
        apb_write(A_M1, 32'h08);
        tick();
        tick();
        check("level_irq", 32'(irq), 32'h1);
        apb_write(A_ST, 32'h08);
        tick();
        tick();
        check("level_irq_stays", 32'(irq), 32'h1);
        read_check("level_status", A_ST, 32'h08);
        gpio_in = 8'h00;
        repeat (6) tick();
        apb_write(A_ST, 32'h08);
        tick();
        check("level_low_irq", 32'(irq), 32'h0);

        // Randomized pins, modes, enables, W1C masks and pad controls.
        en = 8'($urandom_range(0, 255));
        m0 = 8'($urandom_range(0, 255));
        m1 = 8'($urandom_range(0, 255));
        apb_write(A_EN, 32'(en));
        apb_write(A_M0, 32'(m0));
        apb_write(A_M1, 32'(m1));
        apb_write(A_ST, 32'hFF);
        st = '0;
        p  = '0;
        for (int r = 0; r < 12; r++) begin
            v = 8'($urandom_range(0, 255));
            gpio_in = v;
            repeat (6) tick();
            st = st | model_events(p, v, m0, m1);
            check("rnd_irq", 32'(irq), 32'(|(st & en)));
            read_check("rnd_status", A_ST, 32'(st));
            read_check("rnd_in", A_IN, 32'(v));
            m = 8'($urandom_range(0, 255));
            apb_write(A_ST, 32'(m));
            st = (st & ~m) | (v & m0 & m1);
            tick();
            check("rnd_irq_w1c", 32'(irq), 32'(|(st & en)));
            p = v;
            ov  = 8'($urandom_range(0, 255));
            oev = 8'($urandom_range(0, 255));
            odv = 8'($urandom_range(0, 255));
            osv = 8'($urandom_range(0, 255));
            apb_write(A_OUT, 32'(ov));
            apb_write(A_OE, 32'(oev));
            apb_write(A_OD, 32'(odv));
            apb_write(A_OS, 32'(osv));
            check("rnd_pad_out", 32'(gpio_out), 32'(ov));
            check("rnd_pad_oen", 32'(gpio_oen), 32'(model_oen(ov, oev, odv, osv)));
        end

`ifdef GPIO_GEN2_DEBOUNCE_EN
        // Debounce with threshold 4: short glitch filtered, 5-cycle change passes.
        gpio_in = 8'h00;
        apb_write(A_M0, 32'h0);
        apb_write(A_M1, 32'h0);
        apb_write(A_EN, 32'h20);
        repeat (8) tick();
        apb_write(A_ST, 32'hFF);
        apb_write(A_DB, 32'h4);
        tick();
        gpio_in = 8'h20;
        repeat (3) tick();
        gpio_in = 8'h00;
        repeat (10) tick();
        read_check("db_glitch_in", A_IN, 32'h0);
        read_check("db_glitch_status", A_ST, 32'h0);
        gpio_in = 8'h20;
        repeat (8) tick();
        check("db_irq_early", 32'(irq), 32'h0);
        tick();
        check("db_irq", 32'(irq), 32'h1);
        read_check("db_in", A_IN, 32'h20);
`endif

        // Reset in the middle of a write clears state and drops the transfer.
        alt_in = '0; alt_oen = '0;
        apb_write(A_OUT, 32'h55);
        apb_write(A_EN, 32'hFF);
        apb_write(A_M0, 32'hFF);
        apb_write(A_M1, 32'hFF);
        gpio_in = 8'hFF;
        repeat (12) tick();
        check("pre_rst_irq", 32'(irq), 32'h1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = {24'h0, A_OUT, 2'b00}; pwdata = 32'hAA;
        tick();
        penable = 1'b1; prstn = 1'b0; gpio_in = '0;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_pad_out", 32'(gpio_out), 32'h0);
        check("mid_rst_prdata", prdata, 32'h0);
        prstn = 1'b1;
        tick();
        read_check("mid_rst_out", A_OUT, 32'h0);
        read_check("mid_rst_sel0", A_SEL0, 32'h1);
        read_check("mid_rst_en", A_EN, 32'h0);
        read_check("mid_rst_status", A_ST, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
